axi_wr_arbiter: RTL
===================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 64, write data width; byte-select width is DW/8.
REQ-003 SHALL have port clk_i, input, 1, single clock for all logic.
REQ-004 SHALL have port rstn_i, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port mN_req_i, input, 1, requester N (N=0,1) has a burst pending.
REQ-006 SHALL have port mN_waddr_i, input, AW, burst start address, stable while mN_req_i is high.
REQ-007 SHALL have port mN_wlen_i, input, 4, beats minus 1.
REQ-008 SHALL have port mN_wfixed_i, input, 1, fixed-address burst.
REQ-009 SHALL have port mN_wdata_i, input, DW, beat data.
REQ-010 SHALL have port mN_wsel_i, input, DW/8, byte enables.
REQ-011 SHALL have port mN_wvalid_i, input, 1, beat valid.
REQ-012 SHALL have port mN_gnt_o, output, 1, requester N owns the port.
REQ-013 SHALL have port mN_wrdy_o, output, 1, beat accepted for N.
REQ-014 SHALL have port mN_done_o, output, 1, one-cycle pulse on the last beat of N.
REQ-015 SHALL have port mN_werr_o, output, 1, sticky error flag for N.
REQ-016 SHALL have ports axi0_waddr_o (AW), axi0_wlen_o (4), axi0_wfixed_o (1), axi0_wdata_o (DW), axi0_wsel_o (DW/8) and axi0_wvalid_o (1), all outputs, driving the shared PS write port.
REQ-017 SHALL have ports axi0_wrdy_i (1) and axi0_werr_i (1), both inputs, returned by the shared PS write port.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and BURST.
REQ-019 In IDLE with any mN_req_i high, the FSM SHALL select a winner and register mN_gnt_o, waddr, wlen and wfixed, then enter BURST on the next edge; latency from req to gnt is 1 cycle.
REQ-020 When both requests are high, the winner SHALL be the requester indicated by the round-robin pointer; the pointer SHALL move to the other requester after each completed burst.
REQ-021 In BURST, axi0_waddr_o, axi0_wlen_o and axi0_wfixed_o SHALL be the latched values.
REQ-022 In BURST, axi0_wdata_o, axi0_wsel_o and axi0_wvalid_o SHALL be muxed combinationally from the winner.
REQ-023 In BURST, the winner's mN_wrdy_o SHALL equal axi0_wrdy_i; the loser's mN_wrdy_o SHALL be 0.
REQ-024 A 4-bit beat counter SHALL load the latched wlen at grant and decrement on each axi0_wvalid_o & axi0_wrdy_i.
REQ-025 A handshake with the counter at 0 SHALL be the last beat: mN_done_o pulses in that cycle, gnt drops, and the FSM returns to IDLE on the next edge; back-to-back bursts therefore have a minimum 1-cycle IDLE bubble.
REQ-026 A beat count of 16 (wlen=15) SHALL be supported without counter wrap.
REQ-027 A deassertion of mN_req_i mid-burst SHALL be ignored; the burst SHALL complete under mN_wvalid_i control.
REQ-028 In IDLE, all axi0_* outputs SHALL be 0.
REQ-029 axi0_werr_i high in any BURST cycle SHALL set the winner's mN_werr_o.
REQ-030 mN_werr_o SHALL clear only on the next grant to N.
REQ-031 Simultaneous werr and last beat SHALL both take effect.

Reset
REQ-032 rstn_i low SHALL asynchronously force: FSM to IDLE, round-robin pointer to 0, beat counter to 0, latched fields to 0, all outputs to 0 (including werr).
REQ-033 Reset asserted mid-burst SHALL abort the burst immediately with no done pulse.
REQ-034 The first grant after reset SHALL go to m0 if m0_req_i is high.

Configuration
REQ-035 Macro AXI_WR_ARB_FIXED_PRIO_EN defined: m0 SHALL always win simultaneous requests and the round-robin pointer SHALL be removed.
REQ-036 Macro AXI_WR_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-020.

Structure
REQ-037 Package axi_wr_arb_pkg SHALL hold the FSM state enum, the default AW/DW constants and the wlen width constant (4).
REQ-038 Winner selection SHALL live in one sub-module, arb_rr2 (two requests plus pointer in, one-hot grant out).

Verification
REQ-039 m0 req with wlen=3, addr=0x1000_0000, wrdy always 1 SHALL give gnt at +1 cycle, 4 beats on axi0, m0_done on beat 4, and IDLE after.
REQ-040 m0 and m1 requesting simultaneously from reset SHALL give order m0, m1, m0 on repeated requests, each with wlen=0, and a 1-cycle bubble between bursts.
REQ-041 wrdy toggling 1,0,1,0 with wlen=15 SHALL give exactly 16 handshakes, no extra beats, and done on the 16th.
REQ-042 werr pulsed during an m1 burst SHALL set m1_werr_o and leave m0_werr_o at 0; the flag SHALL clear when m1 is next granted.
REQ-043 rstn_i low at beat 2 of 8 SHALL drive axi0_wvalid_o=0 and gnt=0 in the same cycle with no done pulse; after release, m0 SHALL win.
REQ-044 With AXI_WR_ARB_FIXED_PRIO_EN defined and both requesting continuously, m0 SHALL be granted every burst.

Source files
------------

// File: rtl/axi_wr_arb_pkg.sv
// Shared state type and default widths for the two-master AXI write-port arbiter.
package axi_wr_arb_pkg;
  localparam int AXI_WR_ARB_AW = 32;
  localparam int AXI_WR_ARB_DW = 64;
  localparam int WLEN_W        = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;
endpackage

// File: rtl/arb_rr2.sv
// Two-way winner select: a lone requester wins, a tie goes to the pointer (0 = m0, 1 = m1); one-hot out, purely combinational.
module arb_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) o_gnt = i_ptr ? 2'b10 : 2'b01;
    else                o_gnt = i_req;
  end
endmodule

// File: rtl/axi_wr_arbiter.sv
// Arbitrates two burst masters onto one AXI write port: grant 1 cycle after req, beats and wrdy pass through combinationally to the owner only.
// AXI_WR_ARB_FIXED_PRIO_EN selects fixed m0 priority; the default build is round-robin.
module axi_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int AW = AXI_WR_ARB_AW,
  parameter int DW = AXI_WR_ARB_DW
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              m0_req_i,
  input  logic [AW-1:0]     m0_waddr_i,
  input  logic [WLEN_W-1:0] m0_wlen_i,
  input  logic              m0_wfixed_i,
  input  logic [DW-1:0]     m0_wdata_i,
  input  logic [DW/8-1:0]   m0_wsel_i,
  input  logic              m0_wvalid_i,
  output logic              m0_gnt_o,
  output logic              m0_wrdy_o,
  output logic              m0_done_o,
  output logic              m0_werr_o,
  input  logic              m1_req_i,
  input  logic [AW-1:0]     m1_waddr_i,
  input  logic [WLEN_W-1:0] m1_wlen_i,
  input  logic              m1_wfixed_i,
  input  logic [DW-1:0]     m1_wdata_i,
  input  logic [DW/8-1:0]   m1_wsel_i,
  input  logic              m1_wvalid_i,
  output logic              m1_gnt_o,
  output logic              m1_wrdy_o,
  output logic              m1_done_o,
  output logic              m1_werr_o,
  output logic [AW-1:0]     axi0_waddr_o,
  output logic [WLEN_W-1:0] axi0_wlen_o,
  output logic              axi0_wfixed_o,
  output logic [DW-1:0]     axi0_wdata_o,
  output logic [DW/8-1:0]   axi0_wsel_o,
  output logic              axi0_wvalid_o,
  input  logic              axi0_wrdy_i,
  input  logic              axi0_werr_i
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_win;
  logic [AW-1:0]     r_waddr;
  logic [WLEN_W-1:0] r_wlen;
  logic              r_wfixed;
  logic [WLEN_W-1:0] r_cnt;
  logic              r_werr0, r_werr1;
  logic              w_ptr;
  logic [1:0]        w_gnt;
  logic              w_burst, w_start, w_vld, w_hs, w_last;

  arb_rr2 u_arb (
    .i_req ({m1_req_i, m0_req_i}),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt)
  );

  assign w_burst = (r_state == ST_BURST);
  assign w_start = (r_state == ST_IDLE) && (w_gnt != 2'b00);
  assign w_vld   = w_burst && (r_win ? m1_wvalid_i : m0_wvalid_i);
  assign w_hs    = w_vld && axi0_wrdy_i;
  assign w_last  = w_hs && (r_cnt == '0);

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
  assign w_ptr = 1'b0;
`else
  logic r_ptr;

  // After a burst completes, a tie goes to whoever did not own it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)     r_ptr <= 1'b0;
    else if (w_last) r_ptr <= ~r_win;
  end
  assign w_ptr = r_ptr;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    axi0_waddr_o  = '0;
    axi0_wlen_o   = '0;
    axi0_wfixed_o = 1'b0;
    axi0_wdata_o  = '0;
    axi0_wsel_o   = '0;
    axi0_wvalid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        axi0_waddr_o  = r_waddr;
        axi0_wlen_o   = r_wlen;
        axi0_wfixed_o = r_wfixed;
        axi0_wdata_o  = r_win ? m1_wdata_i : m0_wdata_i;
        axi0_wsel_o   = r_win ? m1_wsel_i : m0_wsel_i;
        axi0_wvalid_o = w_vld;
        if (w_last) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The counter holds at zero on the last beat so a 16-beat burst never wraps.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_win    <= 1'b0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wfixed <= 1'b0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_win    <= w_gnt[1];
      r_waddr  <= w_gnt[1] ? m1_waddr_i : m0_waddr_i;
      r_wlen   <= w_gnt[1] ? m1_wlen_i : m0_wlen_i;
      r_wfixed <= w_gnt[1] ? m1_wfixed_i : m0_wfixed_i;
      r_cnt    <= w_gnt[1] ? m1_wlen_i : m0_wlen_i;
    end else if (w_hs && !w_last) begin
      r_cnt    <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_werr0 <= 1'b0;
      r_werr1 <= 1'b0;
    end else begin
      if (w_start && w_gnt[0])                   r_werr0 <= 1'b0;
      else if (w_burst && !r_win && axi0_werr_i) r_werr0 <= 1'b1;
      if (w_start && w_gnt[1])                   r_werr1 <= 1'b0;
      else if (w_burst && r_win && axi0_werr_i)  r_werr1 <= 1'b1;
    end
  end

  assign m0_gnt_o  = w_burst && !r_win;
  assign m1_gnt_o  = w_burst && r_win;
  assign m0_wrdy_o = m0_gnt_o && axi0_wrdy_i;
  assign m1_wrdy_o = m1_gnt_o && axi0_wrdy_i;
  assign m0_done_o = m0_gnt_o && w_last;
  assign m1_done_o = m1_gnt_o && w_last;
  assign m0_werr_o = r_werr0;
  assign m1_werr_o = r_werr1;

endmodule
